key_event_queue: RTL and testbench
==================================

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter NUM_W, default 4, meaning digit value width.
REQ-003 The block SHALL have parameter OP_W, default 2, meaning operator code width.
REQ-004 The block SHALL have parameter FLUSH_ON_CLEAR, default 1, meaning a clear event empties the queue before it is stored.
REQ-005 The block SHALL have port clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: sample enable for the key inputs.
REQ-008 The block SHALL have ports is_num_in, is_op_in, is_eq_in, clear_in, btn_pressed_in, input, 1 bit each: unregistered decoder flags.
REQ-009 The block SHALL have ports num_val_in (NUM_W) and op_val_in (OP_W), input: unregistered decoder values.
REQ-010 The block SHALL have port pop, input, 1 bit: consumer accepts the head entry.
REQ-011 The block SHALL have port clr_flags, input, 1 bit: clears the sticky error flags.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-013 The block SHALL have port ev_type, output, 2 bits: head event type, where NUM=0, OP=1, EQ=2, CLR=3.
REQ-014 The block SHALL have ports ev_num (NUM_W) and ev_op (OP_W), output: head event values.
REQ-015 The block SHALL have port count, output, clog2(DEPTH)+1 bits: number of occupied entries.
REQ-016 The block SHALL have ports overflow and multi_err, output, 1 bit each: sticky error flags.

Function
REQ-017 The block SHALL register btn_pressed_in as btn_prev on every cycle with en=1 and SHALL hold btn_prev while en=0.
REQ-018 A key event SHALL occur when en=1, btn_pressed_in=1 and btn_prev=0; a held button SHALL produce exactly one event.
REQ-019 The event type SHALL be chosen by priority clear_in > is_eq_in > is_op_in > is_num_in.
REQ-020 An event SHALL be dropped silently, with no flag set, when no type flag is asserted.
REQ-021 multi_err SHALL be set when more than one type flag is asserted at an event, and the highest-priority type SHALL still be pushed.
REQ-022 The entry SHALL store num_val_in and op_val_in as sampled; fields not relevant to the type SHALL be stored as zero.
REQ-023 The queue SHALL be first-in first-out; the head entry SHALL drive ev_type, ev_num and ev_op whenever out_valid=1.
REQ-024 Latency: an event pushed at edge N SHALL appear on out_valid and the head outputs after edge N when the queue was empty before the push.
REQ-025 pop while out_valid=1 SHALL remove the head at the same edge; pop while out_valid=0 SHALL be ignored.
REQ-026 Full, with push and no pop: the new event SHALL be dropped, contents SHALL be unchanged, and overflow SHALL be set.
REQ-027 Full, with push and pop together: both SHALL occur, count SHALL be unchanged, and overflow SHALL NOT be set.
REQ-028 Empty, with push and pop together: the pop SHALL be ignored and the push SHALL complete.
REQ-029 With FLUSH_ON_CLEAR=1, a CLR event SHALL discard all entries, including any entry popped in that cycle, and leave only the CLR entry (count=1).
REQ-030 With FLUSH_ON_CLEAR=0, a CLR event SHALL be queued like any other event.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-032 clr_flags SHALL clear overflow and multi_err at the next edge; a same-cycle set SHALL take priority over clr_flags.
REQ-033 out_valid SHALL equal (count != 0) and SHALL be driven from registers only.

Reset
REQ-034 reset=1 at a rising edge SHALL set count=0, out_valid=0, ev_type=0, ev_num=0, ev_op=0, overflow=0, multi_err=0, btn_prev=0, and both pointers to 0.
REQ-035 Reset SHALL take priority over en, pop, clr_flags and any event in the same cycle, including during a partly filled queue.

Verification
REQ-036 Digit 5 held pressed for 10 cycles, then digit 7 pressed -> exactly two entries: (NUM,5) then (NUM,7); count=2.
REQ-037 With DEPTH=4, five distinct presses and no pop -> count=4, overflow=1, fifth event absent; clr_flags -> overflow=0.
REQ-038 Queue full, press with pop in the same cycle -> count stays 4, new event at tail, overflow=0.
REQ-039 is_op_in=1 and is_eq_in=1 on one press -> (EQ) entry, multi_err=1.
REQ-040 With FLUSH_ON_CLEAR=1, three NUM entries queued, then a clear press -> count=1, head=CLR; with FLUSH_ON_CLEAR=0 -> count=4.
REQ-041 Reset asserted with count=3 and a press in the same cycle -> count=0, out_valid=0, all outputs zero at the next edge.

Source files
------------

// File: rtl/key_event_queue.sv
// Key event queue: turns decoded key presses into typed events and buffers
// them in a small FIFO for the calculator core.
//
// state         | meaning
// --------------|-----------------------------------------------------------
// count == 0    | queue empty, out_valid low, head outputs forced to zero
// 0 < count < D | head entry valid, pushes and pops proceed freely
// count == D    | full: a push without a same-cycle pop is dropped (overflow)
module key_event_queue #(
    parameter int DEPTH          = 4,
    parameter int NUM_W          = 4,
    parameter int OP_W           = 2,
    parameter int FLUSH_ON_CLEAR = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       is_num_in,
    input  logic                       is_op_in,
    input  logic                       is_eq_in,
    input  logic                       clear_in,
    input  logic                       btn_pressed_in,
    input  logic [NUM_W-1:0]           num_val_in,
    input  logic [OP_W-1:0]            op_val_in,
    input  logic                       pop,
    input  logic                       clr_flags,
    output logic                       out_valid,
    output logic [1:0]                 ev_type,
    output logic [NUM_W-1:0]           ev_num,
    output logic [OP_W-1:0]            ev_op,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       multi_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] EV_NUM = 2'd0;
    localparam logic [1:0] EV_OP  = 2'd1;
    localparam logic [1:0] EV_EQ  = 2'd2;
    localparam logic [1:0] EV_CLR = 2'd3;

    logic [1:0]       q_type [DEPTH];
    logic [NUM_W-1:0] q_num  [DEPTH];
    logic [OP_W-1:0]  q_op   [DEPTH];

    logic             btn_prev;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             valid_q;
    logic             overflow_q;
    logic             multi_err_q;

    logic             key_event;
    logic [2:0]       flag_cnt;
    logic             push_req;
    logic             pop_ok;
    logic             is_full;
    logic             flush;
    logic             do_push;
    logic             ovf_set;
    logic             multi_set;
    logic [1:0]       new_type;
    logic [NUM_W-1:0] new_num;
    logic [OP_W-1:0]  new_op;

    // Rising edge of the (enabled) button is the only thing that makes an event.
    assign key_event = en & btn_pressed_in & ~btn_prev;
    assign flag_cnt  = 3'(clear_in) + 3'(is_eq_in) + 3'(is_op_in) + 3'(is_num_in);
    assign push_req  = key_event & (clear_in | is_eq_in | is_op_in | is_num_in);
    assign multi_set = key_event & (flag_cnt > 3'd1);

    // Priority-encode the event type and zero fields that do not belong to it.
    always_comb begin
        new_type = EV_NUM;
        new_num  = '0;
        new_op   = '0;
        if (clear_in) begin
            new_type = EV_CLR;
        end else if (is_eq_in) begin
            new_type = EV_EQ;
        end else if (is_op_in) begin
            new_type = EV_OP;
            new_op   = op_val_in;
        end else begin
            new_type = EV_NUM;
            new_num  = num_val_in;
        end
    end

    assign is_full = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop & valid_q;
    // A flushing clear rebuilds the queue around the new entry, so it can never overflow.
    assign flush   = (FLUSH_ON_CLEAR != 0) && push_req && (new_type == EV_CLR);
    assign do_push = push_req & (flush | ~is_full | pop_ok);
    assign ovf_set = push_req & is_full & ~pop_ok & ~flush;

    // Next occupancy and read pointer; flush makes the new entry the only one.
    always_comb begin
        count_nxt  = count_q;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            count_nxt  = CNT_W'(1);
            rd_ptr_nxt = wr_ptr;
        end else begin
            if (pop_ok) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            if (do_push && !pop_ok) begin
                count_nxt = count_q + CNT_W'(1);
            end else if (pop_ok && !do_push) begin
                count_nxt = count_q - CNT_W'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until covered by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_type[wr_ptr] <= new_type;
            q_num[wr_ptr]  <= new_num;
            q_op[wr_ptr]   <= new_op;
        end
    end

    // Control state: edge detector, pointers, occupancy and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            if (en) begin
                btn_prev <= btn_pressed_in;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            valid_q <= (count_nxt != '0);
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (clr_flags) begin
                overflow_q <= 1'b0;
            end
            if (multi_set) begin
                multi_err_q <= 1'b1;
            end else if (clr_flags) begin
                multi_err_q <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign multi_err = multi_err_q;
    assign ev_type   = valid_q ? q_type[rd_ptr] : EV_NUM;
    assign ev_num    = valid_q ? q_num[rd_ptr]  : '0;
    assign ev_op     = valid_q ? q_op[rd_ptr]   : '0;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: one flushing and one non-flushing
// instance share the same stimulus.
module tb_key_event_queue;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       is_num_in = 1'b0, is_op_in = 1'b0, is_eq_in = 1'b0, clear_in = 1'b0;
    logic       btn_pressed_in = 1'b0;
    logic [3:0] num_val_in = '0;
    logic [1:0] op_val_in = '0;
    logic       pop = 1'b0, clr_flags = 1'b0;

    logic       out_valid, overflow, multi_err;
    logic [1:0] ev_type, ev_op;
    logic [3:0] ev_num;
    logic [2:0] count;

    logic       nf_out_valid, nf_overflow, nf_multi_err;
    logic [1:0] nf_ev_type, nf_ev_op;
    logic [3:0] nf_ev_num;
    logic [2:0] nf_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_event_queue #(.DEPTH(4), .NUM_W(4), .OP_W(2), .FLUSH_ON_CLEAR(1)) u_dut (
        .clk(clk), .reset(reset), .en(en),
        .is_num_in(is_num_in), .is_op_in(is_op_in), .is_eq_in(is_eq_in),
        .clear_in(clear_in), .btn_pressed_in(btn_pressed_in),
        .num_val_in(num_val_in), .op_val_in(op_val_in),
        .pop(pop), .clr_flags(clr_flags),
        .out_valid(out_valid), .ev_type(ev_type), .ev_num(ev_num), .ev_op(ev_op),
        .count(count), .overflow(overflow), .multi_err(multi_err)
    );

    key_event_queue #(.DEPTH(4), .NUM_W(4), .OP_W(2), .FLUSH_ON_CLEAR(0)) u_dut_nf (
        .clk(clk), .reset(reset), .en(en),
        .is_num_in(is_num_in), .is_op_in(is_op_in), .is_eq_in(is_eq_in),
        .clear_in(clear_in), .btn_pressed_in(btn_pressed_in),
        .num_val_in(num_val_in), .op_val_in(op_val_in),
        .pop(pop), .clr_flags(clr_flags),
        .out_valid(nf_out_valid), .ev_type(nf_ev_type), .ev_num(nf_ev_num), .ev_op(nf_ev_op),
        .count(nf_count), .overflow(nf_overflow), .multi_err(nf_multi_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] cen, input logic [3:0] nv, input logic [1:0] ov);
        {clear_in, is_eq_in, is_op_in, is_num_in} = cen;
        num_val_in = nv;
        op_val_in  = ov;
    endtask

    // One press cycle (optionally with pop / clr_flags) followed by one release cycle.
    task automatic key(input logic [3:0] cen, input logic [3:0] nv, input logic [1:0] ov,
                       input logic p, input logic cf);
        set_flags(cen, nv, ov);
        btn_pressed_in = 1'b1;
        pop            = p;
        clr_flags      = cf;
        tick();
        set_flags(4'b0000, 4'd0, 2'd0);
        btn_pressed_in = 1'b0;
        pop            = 1'b0;
        clr_flags      = 1'b0;
        tick();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cnt"},  count,     0);
        check({tag, "_vld"},  out_valid, 0);
        check({tag, "_type"}, ev_type,   0);
        check({tag, "_num"},  ev_num,    0);
        check({tag, "_op"},   ev_op,     0);
        check({tag, "_ovf"},  overflow,  0);
        check({tag, "_mul"},  multi_err, 0);
    endtask

    initial begin
        do_reset();
        check_zero("rst");

        // Held digit 5 gives one event, then digit 7.
        set_flags(4'b0001, 4'd5, 2'd0);
        btn_pressed_in = 1'b1;
        tick();
        check("lat_vld", out_valid, 1);
        check("lat_num", ev_num, 5);
        for (int i = 0; i < 9; i++) tick();
        check("held_cnt", count, 1);
        btn_pressed_in = 1'b0;
        tick();
        key(4'b0001, 4'd7, 2'd0, 1'b0, 1'b0);
        check("two_cnt", count, 2);
        check("two_h0_type", ev_type, 0);
        check("two_h0_num", ev_num, 5);
        do_pop();
        check("two_h1_num", ev_num, 7);
        check("two_h1_cnt", count, 1);
        do_pop();
        check("two_empty_vld", out_valid, 0);
        do_pop();
        check("pop_empty_cnt", count, 0);

        // en=0 blocks events and freezes btn_prev.
        en = 1'b0;
        set_flags(4'b0001, 4'd3, 2'd0);
        btn_pressed_in = 1'b1;
        tick();
        check("en0_cnt", count, 0);
        en = 1'b1;
        tick();
        check("en1_cnt", count, 1);
        btn_pressed_in = 1'b0;
        set_flags(4'b0000, 4'd0, 2'd0);
        tick();
        do_pop();

        // Fill to overflow (pointers wrap as they are not at zero here).
        for (int i = 1; i <= 5; i++) key(4'b0001, 4'(i), 2'd0, 1'b0, 1'b0);
        check("full_cnt", count, 4);
        check("full_ovf", overflow, 1);
        check("full_head", ev_num, 1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clrf_ovf", overflow, 0);
        key(4'b0001, 4'd9, 2'd0, 1'b1, 1'b0);
        check("fullpp_cnt", count, 4);
        check("fullpp_ovf", overflow, 0);
        check("fullpp_head", ev_num, 2);
        do_pop();
        check("drain_3", ev_num, 3);
        do_pop();
        check("drain_4", ev_num, 4);
        do_pop();
        check("drain_9", ev_num, 9);
        do_pop();
        check("drain_cnt", count, 0);

        // Multiple flags: EQ wins, multi_err sticky.
        key(4'b0110, 4'd3, 2'd2, 1'b0, 1'b0);
        check("multi_type", ev_type, 2);
        check("multi_num", ev_num, 0);
        check("multi_op", ev_op, 0);
        check("multi_err", multi_err, 1);
        do_pop();
        key(4'b0000, 4'd1, 2'd1, 1'b0, 1'b0);
        check("noflag_cnt", count, 0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clrf_mul", multi_err, 0);
        key(4'b0000, 4'd1, 2'd1, 1'b0, 1'b0);
        check("noflag_mul", multi_err, 0);
        key(4'b0011, 4'd6, 2'd3, 1'b0, 1'b1);
        check("op_type", ev_type, 1);
        check("op_op", ev_op, 3);
        check("op_num", ev_num, 0);
        check("setwin_mul", multi_err, 1);

        // Clear press with and without flush.
        do_reset();
        for (int i = 1; i <= 3; i++) key(4'b0001, 4'(i), 2'd0, 1'b0, 1'b0);
        key(4'b1000, 4'd0, 2'd0, 1'b0, 1'b0);
        check("flush_cnt", count, 1);
        check("flush_type", ev_type, 3);
        check("nf_cnt", nf_count, 4);
        check("nf_head", nf_ev_num, 1);
        do_reset();
        for (int i = 1; i <= 3; i++) key(4'b0001, 4'(i), 2'd0, 1'b0, 1'b0);
        key(4'b1000, 4'd0, 2'd0, 1'b1, 1'b0);
        check("flushpop_cnt", count, 1);
        check("flushpop_type", ev_type, 3);
        check("nfpop_cnt", nf_count, 3);
        check("nfpop_head", nf_ev_num, 2);

        // Reset wins over a same-cycle press with a partly filled queue.
        do_reset();
        for (int i = 1; i <= 3; i++) key(4'b0001, 4'(i + 4), 2'd0, 1'b0, 1'b0);
        check("pre_rst_cnt", count, 3);
        set_flags(4'b0001, 4'd12, 2'd0);
        btn_pressed_in = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("rstpress");
        tick();
        check("post_rst_cnt", count, 1);
        check("post_rst_num", ev_num, 12);
        btn_pressed_in = 1'b0;
        set_flags(4'b0000, 4'd0, 2'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
